// File: rtl/wptr_full_if.sv
`default_nettype none
// ============================================================================
//  Module      : wptr_full_if
//  Description : Write-side bundle of the dual-clock FIFO write-pointer stage.
//                Groups the push request, the read-domain Gray pointer, the
//                overflow clear and every status/address output.
//                master : the write-side user (drives wpush/rptr/wovf_clr)
//                slave  : the wptr_full block
//  Ports       : wpush, rptr[ADDR_W:0], wovf_clr               (master -> slave)
//                wen, waddr[ADDR_W-1:0], wptr[ADDR_W:0], wfull,
//                wafull, wlevel[ADDR_W:0], woverflow           (slave -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface wptr_full_if #(
    parameter int ADDR_W = 4
);
    logic              wpush;
    logic [ADDR_W:0]   rptr;
    logic              wovf_clr;
    logic              wen;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W:0]   wptr;
    logic              wfull;
    logic              wafull;
    logic [ADDR_W:0]   wlevel;
    logic              woverflow;

    modport master (
        output wpush, rptr, wovf_clr,
        input  wen, waddr, wptr, wfull, wafull, wlevel, woverflow
    );

    modport slave (
        input  wpush, rptr, wovf_clr,
        output wen, waddr, wptr, wfull, wafull, wlevel, woverflow
    );
endinterface
`default_nettype wire

// File: rtl/wptr_full.sv
`default_nettype none
// ============================================================================
//  Module      : wptr_full
//  Description : Write-domain pointer and full-flag stage of a dual-clock FIFO.
//                Keeps the binary write count and the Gray write pointer,
//                double-flops the read-domain Gray pointer into wclk and
//                derives registered full, almost-full, fill level and a
//                sticky overflow flag.
//  Ports       : wclk    - write clock (only clock of this block)
//                wrst_n  - asynchronous active-low reset
//                bus     - wptr_full_if.slave (push, read pointer, status)
//  Config      : WPTR_OVF_EN - when defined, builds the sticky overflow
//                register; otherwise woverflow is tied low and wovf_clr is
//                ignored.
//  Revision    : 1.0  initial release
// ============================================================================
module wptr_full #(
    parameter int ADDR_W   = 4,
    parameter int AFULL_TH = 12   // legal range 1 .. 2**ADDR_W
) (
    input  wire logic   wclk,
    input  wire logic   wrst_n,
    wptr_full_if.slave  bus
);

    localparam logic [ADDR_W:0] c_AFULL_TH = AFULL_TH[ADDR_W:0];

    // Gray -> binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
        logic [ADDR_W:0] b;
        b[ADDR_W] = g[ADDR_W];
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_W:0] rq1_q;
    logic [ADDR_W:0] rq2_q;
    logic [ADDR_W:0] wbin_q;
    logic [ADDR_W:0] wgray_q;
    logic [ADDR_W:0] wlevel_q;
    logic            wfull_q;
    logic            wafull_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic            w_wen;
    logic [ADDR_W:0] wbin_d;
    logic [ADDR_W:0] wgray_d;
    logic [ADDR_W:0] rbin_s;
    logic [ADDR_W:0] level_d;
    logic            wfull_d;
    logic            wafull_d;

    always_comb begin
        w_wen    = bus.wpush & ~wfull_q;
        wbin_d   = wbin_q + {{ADDR_W{1'b0}}, w_wen};
        wgray_d  = (wbin_d >> 1) ^ wbin_d;
        // Full when the write pointer is exactly one lap ahead of the read
        // pointer: in Gray code that is the top two bits inverted.
        wfull_d  = (wgray_d == {~rq2_q[ADDR_W:ADDR_W-1], rq2_q[ADDR_W-2:0]});
        rbin_s   = gray2bin(rq2_q);
        // Modular difference; the lagging read pointer only ever makes this
        // larger than the true occupancy, never smaller.
        level_d  = wbin_d - rbin_s;
        wafull_d = (level_d >= c_AFULL_TH);
    end

    // ------------------------------------------------------------------
    // Synchronizer and pointer registers
    // ------------------------------------------------------------------
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            rq1_q    <= '0;
            rq2_q    <= '0;
            wbin_q   <= '0;
            wgray_q  <= '0;
            wlevel_q <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
        end else begin
            // Plain two-flop synchronizer, no logic ahead of the first stage.
            rq1_q    <= bus.rptr;
            rq2_q    <= rq1_q;
            wbin_q   <= wbin_d;
            wgray_q  <= wgray_d;
            wlevel_q <= level_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
        end
    end

    // ------------------------------------------------------------------
    // Sticky overflow
    // ------------------------------------------------------------------
`ifdef WPTR_OVF_EN
    logic woverflow_q;
    logic woverflow_d;

    always_comb begin
        woverflow_d = woverflow_q;
        // A new overflow takes priority over a clear in the same cycle.
        if (bus.wpush && wfull_q) begin
            woverflow_d = 1'b1;
        end else if (bus.wovf_clr) begin
            woverflow_d = 1'b0;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            woverflow_q <= 1'b0;
        end else begin
            woverflow_q <= woverflow_d;
        end
    end

    assign bus.woverflow = woverflow_q;
`else
    logic w_unused_ovf_clr;
    assign w_unused_ovf_clr = bus.wovf_clr;
    assign bus.woverflow    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.wen    = w_wen;
    assign bus.waddr  = wbin_q[ADDR_W-1:0];
    assign bus.wptr   = wgray_q;
    assign bus.wfull  = wfull_q;
    assign bus.wafull = wafull_q;
    assign bus.wlevel = wlevel_q;

endmodule
`default_nettype wire

// File: tb/tb_wptr_full.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wptr_full
//  Description : Self-checking bench for wptr_full (ADDR_W=4, AFULL_TH=12).
//                A count-based reference model (write count, read count and a
//                two-stage delay of the read count) predicts every output.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wptr_full;

    localparam int ADDR_W   = 4;
    localparam int DEPTH    = 16;
    localparam int AFULL_TH = 12;

    logic clk;
    logic rst_n;

    wptr_full_if #(.ADDR_W(ADDR_W)) wif ();

    wptr_full #(
        .ADDR_W  (ADDR_W),
        .AFULL_TH(AFULL_TH)
    ) u_dut (
        .wclk  (clk),
        .wrst_n(rst_n),
        .bus   (wif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state (plain counts, not pointers)
    int  m_wcnt;   // total accepted pushes
    int  m_rcnt;   // read count currently driven on rptr
    int  m_s1;     // read count seen one edge ago
    int  m_s2;     // read count seen two edges ago
    int  m_level;
    bit  m_full;
    bit  m_afull;
    bit  m_ovf;
    logic [4:0] prev_wptr;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [4:0] to_gray(input int cnt);
        logic [4:0] b;
        b = cnt[4:0];
        return b ^ (b >> 1);
    endfunction

    function automatic logic exp_ovf();
`ifdef WPTR_OVF_EN
        return m_ovf;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_wcnt = 0; m_rcnt = 0; m_s1 = 0; m_s2 = 0;
        m_level = 0; m_full = 0; m_afull = 0; m_ovf = 0;
        prev_wptr = '0;
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".wptr"},   32'(wif.wptr),      32'(to_gray(m_wcnt)));
        check_val({tag, ".waddr"},  32'(wif.waddr),     32'(m_wcnt % DEPTH));
        check_val({tag, ".wfull"},  32'(wif.wfull),     32'(m_full));
        check_val({tag, ".wafull"}, 32'(wif.wafull),    32'(m_afull));
        check_val({tag, ".wlevel"}, 32'(wif.wlevel),    32'(m_level));
        check_val({tag, ".wovf"},   32'(wif.woverflow), 32'(exp_ovf()));
        check_val({tag, ".gray1"},  32'($countones(wif.wptr ^ prev_wptr) <= 1), 32'd1);
        prev_wptr = wif.wptr;
    endtask

    // One write-clock cycle: drive at negedge, check wen, apply edge, check outputs.
    task automatic step(input bit push, input bit clr);
        bit m_wen;
        @(negedge clk);
        wif.wpush    = push;
        wif.wovf_clr = clr;
        wif.rptr     = to_gray(m_rcnt);
        #1;
        m_wen = push && !m_full;
        check_val("wen", 32'(wif.wen), 32'(m_wen));
        @(posedge clk);
        if (push && m_full) m_ovf = 1'b1;
        else if (clr)       m_ovf = 1'b0;
        if (m_wen) m_wcnt++;
        m_level = m_wcnt - m_s2;
        m_full  = (m_level == DEPTH);
        m_afull = (m_level >= AFULL_TH);
        m_s2    = m_s1;
        m_s1    = m_rcnt;
        #1;
        check_outputs("step");
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, ".wptr"},   32'(wif.wptr),      32'd0);
        check_val({tag, ".waddr"},  32'(wif.waddr),     32'd0);
        check_val({tag, ".wfull"},  32'(wif.wfull),     32'd0);
        check_val({tag, ".wafull"}, 32'(wif.wafull),    32'd0);
        check_val({tag, ".wlevel"}, 32'(wif.wlevel),    32'd0);
        check_val({tag, ".wovf"},   32'(wif.woverflow), 32'd0);
        check_val({tag, ".wen"},    32'(wif.wen),       32'd0);
    endtask

    // Reset asserted between edges; outputs must clear with no clock edge.
    task automatic async_reset();
        @(negedge clk);
        #2;
        wif.wpush    = 1'b0;
        wif.wovf_clr = 1'b0;
        wif.rptr     = '0;
        rst_n        = 1'b0;
        #1;
        check_all_zero("rst_async");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        wif.wpush    = 1'b0;
        wif.wovf_clr = 1'b0;
        wif.rptr     = '0;
        rst_n        = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("rst_init");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill from empty with a static read pointer
        for (int i = 0; i < DEPTH; i++) begin
            check_val("fill.waddr_pre", 32'(wif.waddr), 32'(i));
            step(1'b1, 1'b0);
            check_val("fill.wafull", 32'(wif.wafull), 32'(i + 1 >= AFULL_TH));
        end
        check_val("fill.wptr_full", 32'(wif.wptr), 32'b11000);
        check_val("fill.wlevel16",  32'(wif.wlevel), 32'd16);
        check_val("fill.wfull",     32'(wif.wfull), 32'd1);

        // Push while full: dropped; overflow (if built) sets, clears, set wins
        step(1'b1, 1'b0);
        check_val("ovf.wptr_hold", 32'(wif.wptr), 32'b11000);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);

        // Drain release: read count 4, then 5
        m_rcnt = 4;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check_val("drain.wfull_hold", 32'(wif.wfull), 32'd1);
        step(1'b0, 1'b0);
        check_val("drain.wfull",  32'(wif.wfull),  32'd0);
        check_val("drain.wlevel", 32'(wif.wlevel), 32'd12);
        check_val("drain.wafull", 32'(wif.wafull), 32'd1);
        m_rcnt = 5;
        repeat (3) step(1'b0, 1'b0);
        check_val("drain.wafull_clr", 32'(wif.wafull), 32'd0);

        // Wrap: 40 pushes with the reader following
        for (int i = 0; i < 40; i++) begin
            if (m_rcnt < m_wcnt) m_rcnt++;
            step(1'b1, 1'b0);
        end

        // Randomized traffic with a mid-burst asynchronous reset
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                async_reset();
                check_val("post_rst.waddr", 32'(wif.waddr), 32'd0);
                step(1'b1, 1'b0);
                check_val("post_rst.waddr1", 32'(wif.waddr), 32'd1);
            end
            if (m_rcnt < m_wcnt && $urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 70))
                m_rcnt += $urandom_range(1, ((m_wcnt - m_rcnt) > 3) ? 3 : (m_wcnt - m_rcnt));
            step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 10);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/wptr_full.md
# wptr_full

Write-domain pointer and full-flag stage of the dual-clock FIFO in the CDC path; it is the upstream counterpart of the read-pointer/empty stage. It accepts push requests in the `wclk` domain and maintains the binary write address and the Gray-coded write pointer exported to the read domain. It synchronizes the read domain's Gray pointer into `wclk` and produces registered full, almost-full, fill-level and overflow status.

## Interface
Parameters:
- `ADDR_W`, default 4: memory address width; FIFO depth = 2^ADDR_W (16); pointers are ADDR_W+1 bits.
- `AFULL_TH`, default 12: fill level at or above which `wafull` asserts; legal range 1..2^ADDR_W.

Ports:
- `wclk`  in  1: write-domain clock; the only clock of this block.
- `wrst_n`  in  1: asynchronous, active-low reset.
- `wpush`  in  1: push request, sampled on rising `wclk`.
- `rptr`  in  ADDR_W+1: Gray read pointer from the read domain (asynchronous to `wclk`).
- `wovf_clr`  in  1: clears sticky overflow.
- `wen`  out  1: memory write strobe, combinational = `wpush & ~wfull`.
- `waddr`  out  ADDR_W: memory write address = low ADDR_W bits of binary write count.
- `wptr`  out  ADDR_W+1: registered Gray write pointer to the read-domain synchronizer.
- `wfull`  out  1: registered full flag.
- `wafull`  out  1: registered almost-full flag.
- `wlevel`  out  ADDR_W+1: registered fill level as seen from write domain (0..2^ADDR_W).
- `woverflow`  out  1: sticky, set by push while full.

## Operation
- Synchronizer: `rptr` passes through two `wclk` flops (`rq1`, `rq2`); only `rq2` is used. No logic between `rptr` and `rq1`.
- Binary count `wbin` (ADDR_W+1 bits, wraps modulo 2^(ADDR_W+1)); `wbin_next = wbin + wen`.
- `wgray_next = (wbin_next >> 1) ^ wbin_next`; `wptr <= wgray_next` each cycle, together with `wbin <= wbin_next`.
- Full: `wfull <= (wgray_next == {~rq2[ADDR_W:ADDR_W-1], rq2[ADDR_W-2:0]})`.
- Level: `rbin_s` = Gray-to-binary of `rq2` (XOR-prefix from MSB); `wlevel <= wbin_next - rbin_s` (mod 2^(ADDR_W+1)); `wafull <= (level_next >= AFULL_TH)`.
- Push while `wfull`=1: dropped, `wen`=0, pointers hold, overflow set (see Configuration).
- `wlevel` is pessimistic (read progress lags by synchronizer delay); never under-reports.
- Reset (any time, asynchronous): `wbin`, `wptr`, `waddr`, `rq1`, `rq2`, `wlevel` = 0; `wfull`, `wafull`, `woverflow` = 0. Read side must be reset in the same event; no partial-reset recovery is defined.

## Timing
- Accepted push at edge N: `waddr`/`wptr` advance at edge N; `wen` valid combinationally in cycle before N.
- 16th accepted push (from empty, `rptr` static) at edge N: `wfull`=1 and `wlevel`=16 from edge N; no gap cycle.
- `rptr` change before edge M: `rq2` updates at M+1; `wfull`/`wlevel`/`wafull` reflect it at M+2.
- `wptr` changes at most one bit per edge (Gray); includes wrap 31->0.
- `wovf_clr` and new overflow in same cycle: set wins.

## Configuration
- `WPTR_OVF_EN` defined: `woverflow` sets on edge where `wpush & wfull`, holds until `wovf_clr` sampled high with no concurrent overflow.
- Not defined: overflow register not built; `woverflow` tied 0; `wovf_clr` ignored. Dropped-push behaviour unchanged.

## Test plan
- Reset: assert `wrst_n`=0 mid-burst, no clock edge -> all outputs 0 immediately; after release, first push writes `waddr`=0.
- Fill: `rptr`=0, 16 consecutive pushes -> `waddr` 0..15, `wafull`=1 after 12th push, `wfull`=1 and `wlevel`=16 after 16th, `wptr`=5'b11000.
- Overflow (`WPTR_OVF_EN`): push while full -> `wen`=0, `wptr` unchanged, `woverflow`=1; pulse `wovf_clr` -> 0; clr with concurrent push-while-full -> stays 1.
- Drain release: full, then drive `rptr`=Gray(4)=5'b00110 -> `wfull`=0, `wlevel`=12 exactly two edges later, `wafull` stays 1; `rptr`=Gray(5) -> `wafull`=0.
- Wrap: 40 pushes interleaved with matching `rptr` advances -> `wptr` single-bit changes every step, 31->0 wrap clean, `wfull` never false-asserts, `wlevel` ≤ 16.
- Macro off: push while full -> `woverflow` stays 0, push still dropped.
